// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage: single-outstanding SRAM-like fetch into a registered IF/ID slot
// Optional IF_ADEL_EN: misaligned PCs raise a fetch address-error in the slot instead of a memory request.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        pc_stall_o,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_addr_ok_i,
    input  logic        inst_data_ok_i,
    input  logic [31:0] inst_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_adel_o
);

    typedef enum logic [1:0] {
        REQ       = 2'd0,
        WAIT_DATA = 2'd1,
        CANCEL    = 2'd2,
        HOLD      = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        slot_free;
    logic        consume;
    logic        misaligned;
    logic        adel_take;
    logic        data_take;
    logic [31:0] req_pc;
    logic [31:0] pend_pc;
    logic [31:0] pend_inst;

`ifdef IF_ADEL_EN
    assign misaligned = (pc_i[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign slot_free = ~if_valid_o | ~stall_i;
    assign consume   = if_valid_o & ~stall_i;
    // An address error completes the "fetch" in place: no memory traffic, PC moves on.
    assign adel_take = (state == REQ) & misaligned & slot_free & ~flush_i;
    assign data_take = (state == WAIT_DATA) & inst_data_ok_i & ~flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= REQ;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            REQ: begin
                if (inst_req_o && inst_addr_ok_i) state_nxt = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (inst_data_ok_i) begin
                    if (flush_i || slot_free) state_nxt = REQ;
                    else                      state_nxt = HOLD;
                end else if (flush_i) begin
                    state_nxt = CANCEL;
                end
            end
            CANCEL: begin
                if (inst_data_ok_i) state_nxt = REQ;
            end
            HOLD: begin
                if (flush_i || slot_free) state_nxt = REQ;
            end
            default: state_nxt = REQ;
        endcase
    end

    always_comb begin
        inst_req_o  = (state == REQ) & ~flush_i & ~misaligned;
        inst_addr_o = pc_i;
        pc_stall_o  = ~(data_take | adel_take);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_pc     <= RESET_PC;
            pend_pc    <= 32'h0;
            pend_inst  <= 32'h0;
            if_valid_o <= 1'b0;
            if_pc_o    <= RESET_PC;
            if_inst_o  <= 32'h0;
            if_adel_o  <= 1'b0;
        end else begin
            if (inst_req_o && inst_addr_ok_i) begin
                req_pc <= pc_i;
            end
            if (flush_i) begin
                if_valid_o <= 1'b0;
            end else if (data_take && slot_free) begin
                if_valid_o <= 1'b1;
                if_pc_o    <= req_pc;
                if_inst_o  <= inst_rdata_i;
                if_adel_o  <= 1'b0;
            end else if (data_take) begin
                // Decode is stalled on a full slot: park the response until it drains.
                pend_pc   <= req_pc;
                pend_inst <= inst_rdata_i;
            end else if ((state == HOLD) && slot_free) begin
                if_valid_o <= 1'b1;
                if_pc_o    <= pend_pc;
                if_inst_o  <= pend_inst;
                if_adel_o  <= 1'b0;
            end else if (adel_take) begin
                if_valid_o <= 1'b1;
                if_pc_o    <= pc_i;
                if_inst_o  <= 32'h0;
                if_adel_o  <= 1'b1;
            end else if (consume) begin
                if_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - directed self-checking bench for if_fetch_stage
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic        pc_stall;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_adel;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    if_fetch_stage #(.RESET_PC(32'hbfc00000)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .pc_i           (pc),
        .stall_i        (stall),
        .flush_i        (flush),
        .pc_stall_o     (pc_stall),
        .inst_req_o     (inst_req),
        .inst_addr_o    (inst_addr),
        .inst_addr_ok_i (addr_ok),
        .inst_data_ok_i (data_ok),
        .inst_rdata_i   (rdata),
        .if_valid_o     (if_valid),
        .if_pc_o        (if_pc),
        .if_inst_o      (if_inst),
        .if_adel_o      (if_adel)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven and checked mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic f, input logic a, input logic d, input logic [31:0] rd);
        stall   = s;
        flush   = f;
        addr_ok = a;
        data_ok = d;
        rdata   = rd;
        #2;
    endtask

    initial begin
        rst = 1'b1; pc = 32'hbfc00000;
        stall = 0; flush = 0; addr_ok = 0; data_ok = 0; rdata = 32'h0;
        tick(); tick();
        check("rst_valid", {31'h0, if_valid}, 32'h0);
        check("rst_pc", if_pc, 32'hbfc00000);
        check("rst_inst", if_inst, 32'h0);
        check("rst_adel", {31'h0, if_adel}, 32'h0);

        // first fetch: addr_ok immediate, data_ok next cycle
        rst = 1'b0;
        drive(0, 0, 1, 0, 32'h0);
        check("f1_req", {31'h0, inst_req}, 32'h1);
        check("f1_addr", inst_addr, 32'hbfc00000);
        check("f1_stall_a", {31'h0, pc_stall}, 32'h1);
        tick();
        drive(0, 0, 0, 1, 32'h3c1d0001);
        check("f1_stall_d", {31'h0, pc_stall}, 32'h0);
        check("f1_noreq", {31'h0, inst_req}, 32'h0);
        tick();
        pc = 32'hbfc00004;

        // slot full and decode stalled while the next response returns -> HOLD
        drive(1, 0, 1, 0, 32'h0);
        check("f1_valid", {31'h0, if_valid}, 32'h1);
        check("f1_pc", if_pc, 32'hbfc00000);
        check("f1_inst", if_inst, 32'h3c1d0001);
        check("f2_req", {31'h0, inst_req}, 32'h1);
        tick();
        drive(1, 0, 0, 1, 32'h24020005);
        check("f2_stall_d", {31'h0, pc_stall}, 32'h0);
        tick();
        pc = 32'hbfc00008;
        drive(1, 0, 0, 0, 32'h0);
        check("hold_noreq", {31'h0, inst_req}, 32'h0);
        check("hold_pcstall", {31'h0, pc_stall}, 32'h1);
        check("hold_valid", {31'h0, if_valid}, 32'h1);
        check("hold_pc", if_pc, 32'hbfc00000);
        check("hold_inst", if_inst, 32'h3c1d0001);
        tick();
        drive(0, 0, 0, 0, 32'h0);
        check("hold_noreq2", {31'h0, inst_req}, 32'h0);
        tick();
        drive(0, 0, 1, 0, 32'h0);
        check("f2_valid", {31'h0, if_valid}, 32'h1);
        check("f2_pc", if_pc, 32'hbfc00004);
        check("f2_inst", if_inst, 32'h24020005);
        check("f3_req", {31'h0, inst_req}, 32'h1);
        check("f3_addr", inst_addr, 32'hbfc00008);
        tick();

        // flush in WAIT_DATA without data_ok -> CANCEL, late data dropped
        drive(0, 1, 0, 0, 32'h0);
        check("fl1_noreq", {31'h0, inst_req}, 32'h0);
        check("fl1_pcstall", {31'h0, pc_stall}, 32'h1);
        tick();
        pc = 32'hbfc00100;
        drive(0, 0, 0, 0, 32'h0);
        check("cancel_valid", {31'h0, if_valid}, 32'h0);
        check("cancel_noreq", {31'h0, inst_req}, 32'h0);
        tick();
        drive(0, 0, 0, 1, 32'hdeadbeef);
        check("cancel_pcstall", {31'h0, pc_stall}, 32'h1);
        check("cancel_noreq2", {31'h0, inst_req}, 32'h0);
        tick();
        drive(0, 0, 1, 0, 32'h0);
        check("cancel_drop", {31'h0, if_valid}, 32'h0);
        check("redir_req", {31'h0, inst_req}, 32'h1);
        check("redir_addr", inst_addr, 32'hbfc00100);
        tick();

        // flush coincident with data_ok -> dropped, back to REQ
        drive(0, 1, 0, 1, 32'h11111111);
        check("fl2_pcstall", {31'h0, pc_stall}, 32'h1);
        tick();
        pc = 32'hbfc00200;

        // addr_ok withheld for three cycles
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 32'h0);
            check("wait_valid", {31'h0, if_valid}, 32'h0);
            check("wait_req", {31'h0, inst_req}, 32'h1);
            check("wait_addr", inst_addr, 32'hbfc00200);
            check("wait_pcstall", {31'h0, pc_stall}, 32'h1);
            tick();
        end
        drive(0, 0, 1, 0, 32'h0);
        tick();
        drive(0, 0, 0, 1, 32'h8c080010);
        check("f4_stall_d", {31'h0, pc_stall}, 32'h0);
        tick();
        pc = 32'hbfc00204;

        // flush with stall on a full slot: flush wins, slot cleared, no request
        drive(1, 1, 1, 0, 32'h0);
        check("f4_valid", {31'h0, if_valid}, 32'h1);
        check("f4_pc", if_pc, 32'hbfc00200);
        check("f4_inst", if_inst, 32'h8c080010);
        check("fl3_noreq", {31'h0, inst_req}, 32'h0);
        tick();
        drive(1, 0, 0, 0, 32'h0);
        check("fl3_valid", {31'h0, if_valid}, 32'h0);
        check("fl3_req", {31'h0, inst_req}, 32'h1);

        // reset mid-transaction returns to REQ
        drive(0, 0, 1, 0, 32'h0);
        tick();
        rst = 1'b1;
        drive(0, 0, 0, 0, 32'h0);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 32'h0);
        check("rst2_req", {31'h0, inst_req}, 32'h1);
        check("rst2_valid", {31'h0, if_valid}, 32'h0);
        check("rst2_pc", if_pc, 32'hbfc00000);

`ifdef IF_ADEL_EN
        pc = 32'hbfc00002;
        drive(0, 0, 1, 0, 32'h0);
        check("adel_noreq", {31'h0, inst_req}, 32'h0);
        check("adel_pcstall", {31'h0, pc_stall}, 32'h0);
        tick();
        pc = 32'hbfc00006;
        drive(1, 0, 0, 0, 32'h0);
        check("adel_valid", {31'h0, if_valid}, 32'h1);
        check("adel_flag", {31'h0, if_adel}, 32'h1);
        check("adel_pc", if_pc, 32'hbfc00002);
        check("adel_inst", if_inst, 32'h0);
        check("adel_wait", {31'h0, pc_stall}, 32'h1);
`else
        pc = 32'hbfc00002;
        drive(0, 0, 0, 0, 32'h0);
        check("noadel_req", {31'h0, inst_req}, 32'h1);
        check("noadel_flag", {31'h0, if_adel}, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
